// File: rtl/fpu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_issue_queue
//  Purpose  : Buffers CPU FP requests in a FIFO and issues them one at a time
//             to the FPU wrapper, with a watchdog on the in-flight operation.
//  Revision : 1.0  initial release
// ============================================================================
module fpu_issue_queue #(
   parameter int MAN_WIDTH = 24,
   parameter int EXP_WIDTH = 8,
   parameter int DEPTH     = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           err_clr,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [3:0]                     req_tag,
   input  logic [MAN_WIDTH+EXP_WIDTH-1:0] req_op1,
   input  logic [MAN_WIDTH+EXP_WIDTH-1:0] req_op2,
   input  logic [2:0]                     req_operator,
   input  logic [2:0]                     req_rm,
   input  logic                           fpu_ready,
   input  logic                           fpu_result_valid,
   output logic                           fpu_in_valid,
   output logic [3:0]                     fpu_tag,
   output logic [MAN_WIDTH+EXP_WIDTH-1:0] fpu_op1,
   output logic [MAN_WIDTH+EXP_WIDTH-1:0] fpu_op2,
   output logic [2:0]                     fpu_operator,
   output logic [2:0]                     fpu_rm,
   output logic [$clog2(DEPTH):0]         count,
   output logic                           busy,
   output logic                           timeout_err
);

   localparam int c_OP_W  = MAN_WIDTH + EXP_WIDTH;
   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_WD_W  = $clog2(TIMEOUT);
   localparam int c_ENT_W = 4 + 2 * c_OP_W + 6;
   localparam logic [c_PTR_W:0]  c_FULL   = (c_PTR_W + 1)'(DEPTH);
   localparam logic [c_WD_W-1:0] c_WD_END = c_WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic [c_ENT_W-1:0]   r_mem [DEPTH];
   logic [c_ENT_W-1:0]   w_head;
   logic [c_PTR_W-1:0]   r_wrPtr;
   logic [c_PTR_W-1:0]   r_rdPtr;
   logic [c_PTR_W:0]     r_count;
   logic [c_WD_W-1:0]    r_wd;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_timeoutSet;

   assign req_ready    = (r_count < c_FULL) && !flush;
   assign w_push       = req_valid && req_ready;
   assign w_head       = r_mem[r_rdPtr];
   assign fpu_in_valid = (r_state == ST_ISSUE);
   assign count        = r_count;
   assign busy         = (r_state != ST_IDLE) || (r_count != '0);

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= {req_tag, req_op1, req_op2, req_operator, req_rm};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_nextState;
   end

   // Result arrival outranks the watchdog expiring in the same cycle.
   always_comb begin
      w_nextState  = r_state;
      w_pop        = 1'b0;
      w_timeoutSet = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if ((r_count != '0) && fpu_ready && !flush) begin
               w_pop       = 1'b1;
               w_nextState = ST_ISSUE;
            end
         end
         ST_ISSUE: w_nextState = ST_BUSY;
         ST_BUSY: begin
            if (fpu_result_valid) begin
               w_nextState = ST_IDLE;
            end else if (r_wd == c_WD_END) begin
               w_nextState  = ST_IDLE;
               w_timeoutSet = 1'b1;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                   r_wd <= '0;
      else if (r_state == ST_ISSUE) r_wd <= '0;
      else if (r_state == ST_BUSY)  r_wd <= r_wd + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fpu_tag      <= '0;
         fpu_op1      <= '0;
         fpu_op2      <= '0;
         fpu_operator <= '0;
         fpu_rm       <= '0;
      end else if (w_pop) begin
         {fpu_tag, fpu_op1, fpu_op2, fpu_operator, fpu_rm} <= w_head;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            timeout_err <= 1'b0;
      else if (w_timeoutSet) timeout_err <= 1'b1;
      else if (err_clr)      timeout_err <= 1'b0;
   end

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_issue_queue
//  Purpose  : Directed self-checking bench for fpu_issue_queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpu_issue_queue;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        err_clr = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_tag = '0;
   logic [31:0] req_op1 = '0;
   logic [31:0] req_op2 = '0;
   logic [2:0]  req_operator = '0;
   logic [2:0]  req_rm = '0;
   logic        fpu_ready = 1'b0;
   logic        fpu_result_valid = 1'b0;
   logic        fpu_in_valid;
   logic [3:0]  fpu_tag;
   logic [31:0] fpu_op1;
   logic [31:0] fpu_op2;
   logic [2:0]  fpu_operator;
   logic [2:0]  fpu_rm;
   logic [2:0]  count;
   logic        busy;
   logic        timeout_err;

   int nChecks = 0;
   int nPass   = 0;

   always #5 clk = ~clk;

   fpu_issue_queue #(.MAN_WIDTH(24), .EXP_WIDTH(8), .DEPTH(4), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .flush(flush), .err_clr(err_clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
      .req_op1(req_op1), .req_op2(req_op2), .req_operator(req_operator),
      .req_rm(req_rm), .fpu_ready(fpu_ready), .fpu_result_valid(fpu_result_valid),
      .fpu_in_valid(fpu_in_valid), .fpu_tag(fpu_tag), .fpu_op1(fpu_op1),
      .fpu_op2(fpu_op2), .fpu_operator(fpu_operator), .fpu_rm(fpu_rm),
      .count(count), .busy(busy), .timeout_err(timeout_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] tag, input logic [31:0] op1, input logic [31:0] op2,
                       input logic [2:0] opr, input logic [2:0] rm);
      req_tag = tag; req_op1 = op1; req_op2 = op2; req_operator = opr; req_rm = rm;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   // From the ISSUE cycle: one BUSY cycle, then the result ends the operation.
   task automatic completeOp();
      step();
      fpu_result_valid = 1'b1;
      step();
      fpu_result_valid = 1'b0;
   endtask

   task automatic expectIssue(input logic [3:0] tag, input logic [2:0] cnt);
      step();
      check("issue_valid", 64'(fpu_in_valid), 64'd1);
      check("issue_tag", 64'(fpu_tag), 64'(tag));
      check("issue_count", 64'(count), 64'(cnt));
   endtask

   initial begin
      // 1: reset state and single-operation latency
      #12;
      check("rst_in_valid", 64'(fpu_in_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_tag", 64'(fpu_tag), 64'd0);
      check("rst_err", 64'(timeout_err), 64'd0);
      reset = 1'b1;
      step();
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      fpu_ready = 1'b1;
      push(4'd3, 32'h3F80_0000, 32'h4000_0000, 3'd0, 3'd0);
      check("t1_count_after_push", 64'(count), 64'd1);
      check("t1_no_early_issue", 64'(fpu_in_valid), 64'd0);
      expectIssue(4'd3, 3'd0);
      check("t1_op1", 64'(fpu_op1), 64'h3F80_0000);
      check("t1_op2", 64'(fpu_op2), 64'h4000_0000);
      step();
      check("t1_valid_one_cycle", 64'(fpu_in_valid), 64'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("t1_still_busy", 64'(busy), 64'd1);
      end
      fpu_result_valid = 1'b1;
      step();
      fpu_result_valid = 1'b0;
      check("t1_idle", 64'(busy), 64'd0);

      // 2: fill, overflow attempt, drain in order
      fpu_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         push(4'(i), 32'h4100_0000 | i, 32'h4200_0000 | i, 3'(i), 3'(7 - i));
      check("t2_full_count", 64'(count), 64'd4);
      check("t2_full_ready", 64'(req_ready), 64'd0);
      push(4'd9, 32'h0, 32'h0, 3'd0, 3'd0);
      check("t2_fifth_dropped", 64'(count), 64'd4);
      fpu_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expectIssue(4'(i), 3'(3 - i));
         check("t2_op1", 64'(fpu_op1), 64'(32'h4100_0000 | i));
         check("t2_op2", 64'(fpu_op2), 64'(32'h4200_0000 | i));
         check("t2_operator", 64'(fpu_operator), 64'(i));
         check("t2_rm", 64'(fpu_rm), 64'(7 - i));
         step();
         step();
         fpu_result_valid = 1'b1;
         step();
         fpu_result_valid = 1'b0;
      end

      // 3: push while full is blocked, push+pop at count 3, pointer wrap
      fpu_ready = 1'b0;
      for (int i = 4; i < 8; i++) push(4'(i), 32'h4300_0000 | i, 32'h0, 3'd1, 3'd2);
      fpu_ready = 1'b1;
      req_tag = 4'd8; req_op1 = 32'h4300_0008; req_valid = 1'b1;
      expectIssue(4'd4, 3'd3);
      req_valid = 1'b0;
      completeOp();
      check("t3_count3", 64'(count), 64'd3);
      req_tag = 4'd8; req_op1 = 32'h4300_0008; req_valid = 1'b1;
      expectIssue(4'd5, 3'd3);
      req_valid = 1'b0;
      completeOp();
      expectIssue(4'd6, 3'd2);
      completeOp();
      expectIssue(4'd7, 3'd1);
      completeOp();
      expectIssue(4'd8, 3'd0);
      check("t3_wrap_op1", 64'(fpu_op1), 64'h4300_0008);
      completeOp();

      // 4: watchdog
      fpu_ready = 1'b0;
      push(4'd10, 32'hA, 32'hA, 3'd0, 3'd0);
      push(4'd11, 32'hB, 32'hB, 3'd0, 3'd0);
      fpu_ready = 1'b1;
      expectIssue(4'd10, 3'd1);
      for (int i = 0; i < 64; i++) step();
      check("t4_err_not_yet", 64'(timeout_err), 64'd0);
      check("t4_still_waiting", 64'(fpu_in_valid), 64'd0);
      step();
      check("t4_err_set", 64'(timeout_err), 64'd1);
      expectIssue(4'd11, 3'd0);
      completeOp();
      check("t4_err_sticky", 64'(timeout_err), 64'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("t4_err_cleared", 64'(timeout_err), 64'd0);

      // 5: flush while busy
      fpu_ready = 1'b0;
      for (int i = 12; i < 16; i++) push(4'(i), 32'h1, 32'h2, 3'd0, 3'd0);
      fpu_ready = 1'b1;
      expectIssue(4'd12, 3'd3);
      fpu_ready = 1'b0;
      step();
      flush = 1'b1; req_valid = 1'b1; req_tag = 4'd1;
      #1;
      check("t5_ready_flush", 64'(req_ready), 64'd0);
      step();
      flush = 1'b0; req_valid = 1'b0;
      check("t5_count_flushed", 64'(count), 64'd0);
      check("t5_busy_inflight", 64'(busy), 64'd1);
      fpu_result_valid = 1'b1;
      step();
      fpu_result_valid = 1'b0;
      check("t5_done", 64'(busy), 64'd0);
      fpu_ready = 1'b1;
      step();
      check("t5_no_issue", 64'(fpu_in_valid), 64'd0);

      // 6: asynchronous reset mid-operation
      fpu_ready = 1'b0;
      push(4'd2, 32'h5, 32'h6, 3'd3, 3'd4);
      push(4'd3, 32'h7, 32'h8, 3'd3, 3'd4);
      fpu_ready = 1'b1;
      expectIssue(4'd2, 3'd1);
      fpu_ready = 1'b0;
      push(4'd4, 32'h9, 32'h9, 3'd0, 3'd0);
      check("t6_busy_two_queued", 64'(count), 64'd2);
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_count", 64'(count), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_tag", 64'(fpu_tag), 64'd0);
      check("t6_rst_op1", 64'(fpu_op1), 64'd0);
      check("t6_rst_operator", 64'(fpu_operator), 64'd0);
      #1;
      reset = 1'b1;
      step();
      fpu_result_valid = 1'b1;
      step();
      fpu_result_valid = 1'b0;
      step();
      check("t6_stale_result", 64'(busy), 64'd0);
      check("t6_stale_valid", 64'(fpu_in_valid), 64'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
